// File: rtl/fp_div_if.sv
// fp_div_if -- operand/result handshake bundle for the sequential FP divider.
//
// Signals (W = 1+EXP_W+MAN_W):
//   in_valid   master->slave  operands a,b valid
//   in_ready   slave->master  divider idle; transfer on in_valid & in_ready
//   a, b       master->slave  dividend / divisor {sign,exp,frac}
//   out_valid  slave->master  result valid, held until out_ready
//   out_ready  master->slave  consumer accepts; transfer on out_valid & out_ready
//   s          slave->master  quotient
//   overf      slave->master  result overflowed to +/-inf (also x/0)
//   underf     slave->master  result underflowed, flushed to +/-0
// Modports: master (operand producer / result consumer), slave (the divider).
interface fp_div_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         overf;
    logic         underf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, s, overf, underf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, s, overf, underf
    );
endinterface

// File: rtl/fp_div_seq.sv
// fp_div_seq -- sequential IEEE-754-style floating-point divider, s = a / b.
//
// Radix-2 restoring mantissa division, one quotient bit per clock, with
// valid/ready handshakes on both sides. Denormal inputs are flushed to zero;
// results out of range saturate to +/-inf (overf) or flush to +/-0 (underf).
//
// Ports:
//   clk    in  clock, all logic on the rising edge
//   rst_n  in  synchronous active-low reset; abandons any division in flight
//   io     fp_div_if.slave: in_valid/in_ready/a/b, out_valid/out_ready/s/overf/underf
//
// Parameters: EXP_W (exponent width), MAN_W (stored fraction width).
//
// Build option: define FP_DIV_ROUND_EN for round-to-nearest-even; without it
// the quotient is truncated (round toward zero). Latency is the same either way.
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic    clk,
    input  logic    rst_n,
    fp_div_if.slave io
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;     // signed working exponent
    localparam int RW = MAN_W + 2;     // remainder: < 2*divisor after the shift
    localparam int QW = MAN_W + 3;     // hidden bit + fraction + guard + one extra
    localparam int CW = $clog2(QW);

    localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE   = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO  = '0;
    localparam logic [CW-1:0]        CNT_LAST = CW'(QW - 1);
    localparam logic [W-1:0]         QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, ITER, NORM, DONE} state_t;
    state_t state_reg, state_next;

    logic [W-1:0]         a_reg, b_reg, s_reg;
    logic                 overf_reg, underf_reg;
    logic signed [EW-1:0] e_reg;
    logic [RW-1:0]        r_reg;
    logic [QW-1:0]        q_reg;
    logic [CW-1:0]        cnt_reg;

    // ---------------------------------------------------------------- unpack
    logic             sa, sb, sign_w;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign {sa, ea, fa} = a_reg;
    assign {sb, eb, fb} = b_reg;
    assign sign_w = sa ^ sb;

    // Exponent field 0 means zero: denormals are flushed, fraction ignored.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);

    logic signed [EW-1:0] e_init;
    assign e_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;

    // ------------------------------------------------------- special operands
    logic         spec_hit, spec_ovf;
    logic [W-1:0] spec_s;

    always_comb begin
        spec_hit = 1'b1;
        spec_ovf = 1'b0;
        spec_s   = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_s = QNAN;
        end else if (a_inf) begin
            // inf / anything-else (including inf/0) is a plain infinity
            spec_s = {sign_w, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            spec_s   = {sign_w, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_ovf = 1'b1;
        end else if (a_zero || b_inf) begin
            spec_s = {sign_w, {(W-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ------------------------------------------------------ restoring step
    logic [RW-1:0] div_ext, r_diff, r_sel;
    logic          r_ge;

    assign div_ext = {1'b0, 1'b1, fb};
    assign r_ge    = (r_reg >= div_ext);
    assign r_diff  = r_reg - div_ext;
    assign r_sel   = r_ge ? r_diff : r_reg;

    // ------------------------------------------- normalise / round / range
    // q is ma/mb in (0.5, 2) with MAN_W+2 fractional bits. If its MSB is 0 the
    // leading one sits one place lower, so the fraction window moves down one.
    logic                 q_msb, round_up;
    logic [MAN_W-1:0]     frac_t, frac_r;
    logic [MAN_W:0]       frac_sum;
    logic signed [EW-1:0] e_n, e_r;
    logic [W-1:0]         norm_s;
    logic                 norm_ovf, norm_unf;
`ifdef FP_DIV_ROUND_EN
    logic                 guard, sticky;
`endif

    assign q_msb = q_reg[QW-1];

    always_comb begin
        frac_t = q_msb ? q_reg[QW-2:2] : q_reg[QW-3:1];
        e_n    = q_msb ? e_reg : e_reg - E_ONE;
`ifdef FP_DIV_ROUND_EN
        guard    = q_msb ? q_reg[1] : q_reg[0];
        // a non-zero final remainder means the quotient was inexact below q
        sticky   = (q_msb & q_reg[0]) | (|r_reg);
        round_up = guard & (sticky | frac_t[0]);
`else
        round_up = 1'b0;
`endif
        frac_sum = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
        if (frac_sum[MAN_W]) begin
            // 1.11..1 rounded up to 10.0: renormalise
            frac_r = '0;
            e_r    = e_n + E_ONE;
        end else begin
            frac_r = frac_sum[MAN_W-1:0];
            e_r    = e_n;
        end

        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        if (e_r >= EXP_MAX) begin
            norm_s   = {sign_w, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_ovf = 1'b1;
        end else if (e_r <= E_ZERO) begin
            norm_s   = {sign_w, {(W-1){1'b0}}};
            norm_unf = 1'b1;
        end else begin
            norm_s = {sign_w, e_r[EXP_W-1:0], frac_r};
        end
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (io.in_valid) state_next = PREP;
            PREP: state_next = spec_hit ? DONE : ITER;
            ITER: if (cnt_reg == CNT_LAST) state_next = NORM;
            NORM: state_next = DONE;
            DONE: if (io.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            e_reg      <= '0;
            r_reg      <= '0;
            q_reg      <= '0;
            cnt_reg    <= '0;
            s_reg      <= '0;
            overf_reg  <= 1'b0;
            underf_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (io.in_valid) begin
                        a_reg      <= io.a;
                        b_reg      <= io.b;
                        overf_reg  <= 1'b0;
                        underf_reg <= 1'b0;
                    end
                end
                PREP: begin
                    e_reg   <= e_init;
                    r_reg   <= {1'b0, 1'b1, fa};
                    q_reg   <= '0;
                    cnt_reg <= '0;
                    if (spec_hit) begin
                        s_reg      <= spec_s;
                        overf_reg  <= spec_ovf;
                        underf_reg <= 1'b0;
                    end
                end
                ITER: begin
                    r_reg   <= r_sel << 1;
                    q_reg   <= {q_reg[QW-2:0], r_ge};
                    cnt_reg <= cnt_reg + 1'b1;
                end
                NORM: begin
                    s_reg      <= norm_s;
                    overf_reg  <= norm_ovf;
                    underf_reg <= norm_unf;
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state_reg == IDLE);
    assign io.out_valid = (state_reg == DONE);
    assign io.s         = s_reg;
    assign io.overf     = overf_reg;
    assign io.underf    = underf_reg;
endmodule
